// File: rtl/mem_stage.sv
// Memory-access pipeline stage: decodes the EX->MEM memory op and runs one SRAM-style
// request/addr_ok/data_ok transaction per load/store, producing the MEM->WB bus.
module mem_stage #(
  parameter int unsigned EX2MEMBusSize = 106,
  parameter int unsigned MEM2WBBusSize = 70
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [EX2MEMBusSize-1:0] ex2mem_bus_i,
  input  logic                     ctl_mem_valid_i,
  input  logic                     ctl_wb_allow_in_i,
  output logic                     ctl_mem_over_o,
  output logic                     ctl_mem_allow_in_o,
  output logic [MEM2WBBusSize-1:0] mem2wb_bus_o,
  output logic                     mem_ale_o,
  output logic                     data_req_o,
  output logic                     data_wr_o,
  output logic [1:0]               data_size_o,
  output logic [3:0]               data_wstrb_o,
  output logic [31:0]              data_addr_o,
  output logic [31:0]              data_wdata_o,
  input  logic                     data_addr_ok_i,
  input  logic                     data_data_ok_i,
  input  logic [31:0]              data_rdata_i
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLh  = 4'd2;
  localparam logic [3:0] OpLw  = 4'd3;
  localparam logic [3:0] OpLbu = 4'd4;
  localparam logic [3:0] OpLhu = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  // EX->MEM bus fields
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [3:0]  mem_op;
  logic        rf_we;
  logic [4:0]  rf_waddr;

  assign pc         = ex2mem_bus_i[105:74];
  assign alu_result = ex2mem_bus_i[73:42];
  assign store_data = ex2mem_bus_i[41:10];
  assign mem_op     = ex2mem_bus_i[9:6];
  assign rf_we      = ex2mem_bus_i[5];
  assign rf_waddr   = ex2mem_bus_i[4:0];

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_load;
  logic        is_store;
  logic        is_mem;
  logic        misaligned;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        handoff;
  logic [31:0] wb_data;

  // Operation decode: size, strobes, write data and alignment
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    size       = 2'd2;
    wstrb      = 4'b0000;
    wdata      = store_data;
    unique case (mem_op)
      OpLb, OpLbu: begin
        is_load = 1'b1;
        size    = 2'd0;
      end
      OpLh, OpLhu: begin
        is_load    = 1'b1;
        size       = 2'd1;
        misaligned = alu_result[0];
      end
      OpLw: begin
        is_load    = 1'b1;
        size       = 2'd2;
        misaligned = |alu_result[1:0];
      end
      OpSb: begin
        is_store = 1'b1;
        size     = 2'd0;
        wstrb    = 4'b0001 << alu_result[1:0];
        wdata    = {4{store_data[7:0]}};
      end
      OpSh: begin
        is_store   = 1'b1;
        size       = 2'd1;
        misaligned = alu_result[0];
        wstrb      = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
      end
      OpSw: begin
        is_store   = 1'b1;
        size       = 2'd2;
        misaligned = |alu_result[1:0];
        wstrb      = 4'b1111;
      end
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

  // Load lane select and extension
  always_comb begin
    byte_sel = 8'h00;
    unique case (alu_result[1:0])
      2'd0: byte_sel = data_rdata_i[7:0];
      2'd1: byte_sel = data_rdata_i[15:8];
      2'd2: byte_sel = data_rdata_i[23:16];
      2'd3: byte_sel = data_rdata_i[31:24];
      default: ;
    endcase
    half_sel = alu_result[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    load_ext = data_rdata_i;
    unique case (mem_op)
      OpLb:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   load_ext = {24'h0, byte_sel};
      OpLh:    load_ext = {{16{half_sel[15]}}, half_sel};
      OpLhu:   load_ext = {16'h0, half_sel};
      default: load_ext = data_rdata_i;
    endcase
  end

  // Handshake and request outputs
  always_comb begin
    ctl_mem_over_o = 1'b0;
    if (ctl_mem_valid_i) begin
      unique case (state_q)
        StIdle:  ctl_mem_over_o = !is_mem || misaligned;
        StDone:  ctl_mem_over_o = 1'b1;
        default: ctl_mem_over_o = 1'b0;
      endcase
    end
    handoff            = ctl_mem_over_o && ctl_wb_allow_in_i;
    ctl_mem_allow_in_o = !ctl_mem_valid_i || handoff;
    mem_ale_o          = ctl_mem_valid_i && is_mem && misaligned;
    // Request is blanked during reset so the shared-reset slave never sees it
    data_req_o = !rst_i && ctl_mem_valid_i && (state_q == StIdle) && is_mem && !misaligned;
  end

  assign data_wr_o    = is_store;
  assign data_size_o  = size;
  assign data_wstrb_o = wstrb;
  assign data_addr_o  = alu_result;
  assign data_wdata_o = wdata;

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (data_req_o && data_addr_ok_i) state_d = StWait;
      end
      StWait: begin
        if (data_data_ok_i) begin
          state_d = StDone;
          rdata_d = is_load ? load_ext : 32'h0;
        end
      end
      StDone: begin
        if (handoff) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_data      = (state_q == StDone && is_load) ? rdata_q : alu_result;
  assign mem2wb_bus_o = {pc, wb_data, rf_we && !(is_mem && misaligned), rf_waddr};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected MEM->WB buses into a queue, a monitor
// pops and compares on every handoff; request-side fields are checked inline.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [105:0] ex2mem_bus;
  logic         valid;
  logic         wb_allow;
  logic         ctl_mem_over_o;
  logic         ctl_mem_allow_in_o;
  logic [69:0]  mem2wb_bus_o;
  logic         mem_ale_o;
  logic         data_req_o;
  logic         data_wr_o;
  logic [1:0]   data_size_o;
  logic [3:0]   data_wstrb_o;
  logic [31:0]  data_addr_o;
  logic [31:0]  data_wdata_o;
  logic         addr_ok;
  logic         data_ok;
  logic [31:0]  rdata;

  int errors = 0;
  int checks = 0;
  logic [69:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .ex2mem_bus_i       (ex2mem_bus),
    .ctl_mem_valid_i    (valid),
    .ctl_wb_allow_in_i  (wb_allow),
    .ctl_mem_over_o     (ctl_mem_over_o),
    .ctl_mem_allow_in_o (ctl_mem_allow_in_o),
    .mem2wb_bus_o       (mem2wb_bus_o),
    .mem_ale_o          (mem_ale_o),
    .data_req_o         (data_req_o),
    .data_wr_o          (data_wr_o),
    .data_size_o        (data_size_o),
    .data_wstrb_o       (data_wstrb_o),
    .data_addr_o        (data_addr_o),
    .data_wdata_o       (data_wdata_o),
    .data_addr_ok_i     (addr_ok),
    .data_data_ok_i     (data_ok),
    .data_rdata_i       (rdata)
  );

  function automatic logic [105:0] mk_bus(input logic [31:0] pc, input logic [31:0] alu,
                                          input logic [31:0] sd, input logic [3:0] op,
                                          input logic we, input logic [4:0] wa);
    return {pc, alu, sd, op, we, wa};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every handoff must match the oldest expected bus
  always @(negedge clk) begin
    if (!rst && ctl_mem_over_o && wb_allow) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", mem2wb_bus_o);
      end else begin
        logic [69:0] e;
        e = exp_q.pop_front();
        if (mem2wb_bus_o !== e) begin
          errors++;
          $display("FAIL sb_bus: got %h expected %h at %0t", mem2wb_bus_o, e, $time);
        end
      end
    end
  end

  task automatic do_alu(input logic [105:0] bus, input logic [31:0] exp_wb,
                        input logic exp_we, input logic exp_ale);
    @(posedge clk); #1;
    ex2mem_bus = bus; valid = 1'b1; wb_allow = 1'b1;
    exp_q.push_back({bus[105:74], exp_wb, exp_we, bus[4:0]});
    @(negedge clk);
    chk("alu_over", 32'(ctl_mem_over_o), 32'd1);
    chk("alu_allow_in", 32'(ctl_mem_allow_in_o), 32'd1);
    chk("alu_ale", 32'(mem_ale_o), 32'(exp_ale));
    chk("alu_req", 32'(data_req_o), 32'd0);
  endtask

  task automatic do_mem(input logic [105:0] bus, input int aw, input int dw,
                        input logic [31:0] rd, input logic [31:0] exp_wb, input logic exp_we,
                        input logic exp_wr, input logic [1:0] exp_size,
                        input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                        input int hold);
    @(posedge clk); #1;
    ex2mem_bus = bus; valid = 1'b1; wb_allow = 1'b1; addr_ok = 1'b0; data_ok = 1'b0;
    exp_q.push_back({bus[105:74], exp_wb, exp_we, bus[4:0]});
    for (int i = 0; i < aw; i++) begin
      @(negedge clk);
      chk("req_held", 32'(data_req_o), 32'd1);
      chk("over_idle", 32'(ctl_mem_over_o), 32'd0);
      @(posedge clk); #1;
    end
    addr_ok = 1'b1;
    @(negedge clk);
    chk("req", 32'(data_req_o), 32'd1);
    chk("addr", data_addr_o, bus[73:42]);
    chk("wr", 32'(data_wr_o), 32'(exp_wr));
    chk("size", 32'(data_size_o), 32'(exp_size));
    chk("wstrb", 32'(data_wstrb_o), 32'(exp_wstrb));
    chk("wdata", data_wdata_o, exp_wdata);
    @(posedge clk); #1;
    addr_ok = 1'b0;
    for (int i = 0; i < dw; i++) begin
      @(negedge clk);
      chk("req_wait", 32'(data_req_o), 32'd0);
      chk("over_wait", 32'(ctl_mem_over_o), 32'd0);
      @(posedge clk); #1;
    end
    data_ok = 1'b1; rdata = rd;
    @(negedge clk);
    chk("over_dok", 32'(ctl_mem_over_o), 32'd0);
    @(posedge clk); #1;
    data_ok = 1'b0; rdata = 32'hDEAD_BEEF;
    if (hold > 0) begin
      wb_allow = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_over", 32'(ctl_mem_over_o), 32'd1);
        chk("hold_allow_in", 32'(ctl_mem_allow_in_o), 32'd0);
        chk("hold_wb_data", mem2wb_bus_o[37:6], exp_wb);
        @(posedge clk); #1;
      end
      wb_allow = 1'b1;
    end
    @(negedge clk);
    chk("done_over", 32'(ctl_mem_over_o), 32'd1);
    chk("done_allow_in", 32'(ctl_mem_allow_in_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b1; wb_allow = 1'b1; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    ex2mem_bus = mk_bus(32'h1000_0000, 32'h100, 32'h0, 4'd3, 1'b1, 5'd3);
    @(negedge clk);
    chk("rst_req", 32'(data_req_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", 32'(data_req_o), 32'd1);
    chk("post_rst_addr", data_addr_o, 32'h100);
    chk("post_rst_size", 32'(data_size_o), 32'd2);
    do_mem(ex2mem_bus, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 0);

    do_alu(mk_bus(32'h1000_0004, 32'h1234, 32'h0, 4'd0, 1'b1, 5'd5), 32'h1234, 1'b1, 1'b0);

    do_mem(mk_bus(32'h1000_0008, 32'h103, 32'h0, 4'd1, 1'b1, 5'd6), 2, 2, 32'h80FF_FF7F,
           32'hFFFF_FF80, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 0);
    do_mem(mk_bus(32'h1000_000C, 32'h103, 32'h0, 4'd4, 1'b1, 5'd7), 2, 2, 32'h80FF_FF7F,
           32'h0000_0080, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0, 0);
    do_mem(mk_bus(32'h1000_0010, 32'h102, 32'h0, 4'd2, 1'b1, 5'd8), 0, 0, 32'h8001_1234,
           32'hFFFF_8001, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 0);
    do_mem(mk_bus(32'h1000_0014, 32'h102, 32'h0, 4'd5, 1'b1, 5'd9), 0, 1, 32'h8001_1234,
           32'h0000_8001, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0, 0);

    do_mem(mk_bus(32'h1000_0018, 32'h202, 32'hAAAA_BEEF, 4'd7, 1'b0, 5'd0), 1, 0, 32'h0,
           32'h202, 1'b0, 1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF, 0);
    do_mem(mk_bus(32'h1000_001C, 32'h201, 32'h1234_56EF, 4'd6, 1'b0, 5'd0), 0, 0, 32'h0,
           32'h201, 1'b0, 1'b1, 2'd0, 4'b0010, 32'hEFEF_EFEF, 0);
    do_mem(mk_bus(32'h1000_0020, 32'h204, 32'h1122_3344, 4'd8, 1'b0, 5'd0), 0, 0, 32'h0,
           32'h204, 1'b0, 1'b1, 2'd2, 4'b1111, 32'h1122_3344, 0);

    do_alu(mk_bus(32'h1000_0024, 32'h102, 32'h0, 4'd3, 1'b1, 5'd10), 32'h102, 1'b0, 1'b1);
    do_alu(mk_bus(32'h1000_0028, 32'h203, 32'h0, 4'd7, 1'b0, 5'd0), 32'h203, 1'b0, 1'b1);
    do_alu(mk_bus(32'h1000_002C, 32'h77, 32'h0, 4'd12, 1'b1, 5'd11), 32'h77, 1'b1, 1'b0);

    do_mem(mk_bus(32'h1000_0030, 32'h108, 32'h0, 4'd3, 1'b1, 5'd12), 0, 0, 32'h5555_AAAA,
           32'h5555_AAAA, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0, 4);

    // Asynchronous reset in WAIT
    @(posedge clk); #1;
    ex2mem_bus = mk_bus(32'h1000_0034, 32'h300, 32'h0, 4'd3, 1'b1, 5'd13);
    valid = 1'b1; addr_ok = 1'b1;
    @(negedge clk);
    chk("rw_req", 32'(data_req_o), 32'd1);
    @(posedge clk); #1;
    addr_ok = 1'b0;
    @(negedge clk);
    chk("rw_wait_req", 32'(data_req_o), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rw_rst_req", 32'(data_req_o), 32'd0);
    chk("rw_rst_over", 32'(ctl_mem_over_o), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("rw_idle_req", 32'(data_req_o), 32'd1);
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    chk("inv_req", 32'(data_req_o), 32'd0);
    chk("inv_over", 32'(ctl_mem_over_o), 32'd0);
    chk("inv_allow_in", 32'(ctl_mem_allow_in_o), 32'd1);
    chk("inv_ale", 32'(mem_ale_o), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
